// File: rtl/exe_muldiv_sched_if.sv
// Control bundle between the EXE/hazard logic and the multiply/divide scheduler.
// The master side drives requests and flush/back-pressure; the slave side is the scheduler.
interface exe_muldiv_sched_if;
  logic i_EXE_mult_req;
  logic i_EXE_div_req;
  logic i_EXE_signed;
  logic i_EXE_divisor_zero;
  logic i_flush;
  logic i_MEM_stall;
  logic o_mult_start;
  logic o_div_start;
  logic o_unit_signed;
  logic o_unit_abort;
  logic o_EXE_stall;
  logic o_EXE_MEM_ena;
  logic o_busy;
  logic o_result_valid;
  logic o_div_by_zero;

  modport master (
    output i_EXE_mult_req, i_EXE_div_req, i_EXE_signed, i_EXE_divisor_zero,
           i_flush, i_MEM_stall,
    input  o_mult_start, o_div_start, o_unit_signed, o_unit_abort,
           o_EXE_stall, o_EXE_MEM_ena, o_busy, o_result_valid, o_div_by_zero
  );

  modport slave (
    input  i_EXE_mult_req, i_EXE_div_req, i_EXE_signed, i_EXE_divisor_zero,
           i_flush, i_MEM_stall,
    output o_mult_start, o_div_start, o_unit_signed, o_unit_abort,
           o_EXE_stall, o_EXE_MEM_ena, o_busy, o_result_valid, o_div_by_zero
  );
endinterface

// File: rtl/exe_muldiv_sched.sv
// Sequences the shared multi-cycle multiplier/divider beside the EXE stage: start/abort,
// EXE stall, EXE->MEM enable gating, and result hold under MEM back-pressure.
module exe_muldiv_sched #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6
) (
  input  logic               clk,
  input  logic               resetn,
  exe_muldiv_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sgn, sgn_n;
  logic             dbz, dbz_n;

  logic mult_start, div_start, abort, stall, busy, result_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      sgn   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sgn   <= sgn_n;
      dbz   <= dbz_n;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that skipped one
  // would infer a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sgn_n        = sgn;
    dbz_n        = dbz;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    abort        = 1'b0;
    stall        = 1'b0;
    busy         = (state == MULT_RUN) || (state == DIV_RUN);
    result_valid = (state == DONE);

    if (bus.i_flush) begin
      // Flush beats everything: no issue, no stall, kill the unit only if it is running.
      state_n = IDLE;
      cnt_n   = '0;
      dbz_n   = 1'b0;
      abort   = busy;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_EXE_div_req) begin
            stall = 1'b1;
            sgn_n = bus.i_EXE_signed;
            if (bus.i_EXE_divisor_zero) begin
              state_n = DONE;
              dbz_n   = 1'b1;
            end else begin
              div_start = 1'b1;
              cnt_n     = CNT_W'(DIV_CYCLES - 1);
              state_n   = DIV_RUN;
            end
          end else if (bus.i_EXE_mult_req) begin
            stall      = 1'b1;
            sgn_n      = bus.i_EXE_signed;
            mult_start = 1'b1;
            cnt_n      = CNT_W'(MULT_CYCLES - 1);
            state_n    = MULT_RUN;
          end
        end
        MULT_RUN, DIV_RUN: begin
          stall = 1'b1;
          if (cnt == '0) state_n = DONE;
          else           cnt_n   = cnt - 1'b1;
        end
        DONE: begin
          // The request is still high here; leaving only through IDLE keeps it from restarting.
          if (!bus.i_MEM_stall) begin
            state_n = IDLE;
            dbz_n   = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Combinational outputs are forced low during reset so the pipeline sees no enable or pulse.
  assign bus.o_mult_start   = resetn & mult_start;
  assign bus.o_div_start    = resetn & div_start;
  assign bus.o_unit_signed  = resetn & sgn;
  assign bus.o_unit_abort   = resetn & abort;
  assign bus.o_EXE_stall    = resetn & stall;
  assign bus.o_EXE_MEM_ena  = resetn & ~stall & ~bus.i_MEM_stall;
  assign bus.o_busy         = resetn & busy;
  assign bus.o_result_valid = resetn & result_valid;
  assign bus.o_div_by_zero  = resetn & dbz;

endmodule

// File: tb/tb_exe_muldiv_sched.sv
// Directed bench for exe_muldiv_sched with hand-computed output vectors per cycle.
// Vector order: {mult_start, div_start, unit_signed, abort, stall, ena, busy, result_valid, dbz}.
module tb_exe_muldiv_sched;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  exe_muldiv_sched_if bus();

  exe_muldiv_sched #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (33),
    .CNT_W       (6)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.o_mult_start, bus.o_div_start, bus.o_unit_signed, bus.o_unit_abort,
            bus.o_EXE_stall, bus.o_EXE_MEM_ena, bus.o_busy, bus.o_result_valid,
            bus.o_div_by_zero};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mult, input logic div, input logic sg,
                        input logic dz, input logic fl, input logic ms);
    bus.i_EXE_mult_req     = mult;
    bus.i_EXE_div_req      = div;
    bus.i_EXE_signed       = sg;
    bus.i_EXE_divisor_zero = dz;
    bus.i_flush            = fl;
    bus.i_MEM_stall        = ms;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset: everything low even with a request and no MEM stall.
    cyc(); #1;
    check("reset_outs", outs(), 9'b000000000);
    cyc();
    resetn = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("idle_after_reset", outs(), 9'b000001000);

    // Multiply: start at T, stall T..T+4, DONE at T+5, IDLE at T+6.
    cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("mult_start_T", outs(), 9'b100010000);
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1 check($sformatf("mult_run_T%0d", i), outs(), 9'b000010100);
    end
    cyc(); #1 check("mult_done_T5", outs(), 9'b000001010);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("mult_idle_T6", outs(), 9'b000001000);

    // IDLE with MEM stall: enable drops.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("idle_mem_stall", outs(), 9'b000000000);

    // Divide by zero: stall only at T, DONE with dbz at T+1, request held must not restart.
    cyc(); set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("dbz_T", outs(), 9'b000010000);
    cyc(); #1 check("dbz_done", outs(), 9'b001001011);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("dbz_idle", outs(), 9'b001001000);

    // Divide with MEM back-pressure in DONE for 3 cycles.
    cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("div_start_T", outs(), 9'b011010000);
    for (int i = 1; i <= 33; i++) begin
      cyc(); #1 check($sformatf("div_run_T%0d", i), outs(), 9'b000010100);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 check($sformatf("div_hold_%0d", i), outs(), 9'b000000010);
    end
    cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("div_release", outs(), 9'b000001010);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("div_idle", outs(), 9'b000001000);

    // Flush at cycle 10 of a divide.
    cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("fl_div_start", outs(), 9'b010010000);
    for (int i = 1; i <= 9; i++) cyc();
    cyc(); set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("fl_abort", outs(), 9'b000101100);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("fl_idle", outs(), 9'b000001000);

    // Flush and request in the same IDLE cycle: nothing issued.
    cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("fl_req_same", outs(), 9'b000001000);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("fl_req_after", outs(), 9'b000001000);

    // Both requests: divide wins, signed latched.
    cyc(); set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("both_T", outs(), 9'b010010000);
    cyc(); #1 check("both_divrun", outs(), 9'b001010100);
    cyc(); set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 check("both_flush", outs(), 9'b001101100);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("both_idle", outs(), 9'b001001000);

    // Reset during MULT_RUN, then a clean restart.
    cyc(); set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("rst_mult_T", outs(), 9'b101010000);
    cyc(); #1 check("rst_mult_run", outs(), 9'b000010100);
    resetn = 1'b0;
    #1 check("rst_async", outs(), 9'b000000000);
    cyc(); #1 check("rst_held", outs(), 9'b000000000);
    cyc(); resetn = 1'b1;
    #1 check("rst_restart_T", outs(), 9'b100010000);
    for (int i = 1; i <= 4; i++) cyc();
    cyc(); #1 check("rst_restart_done", outs(), 9'b000001010);
    cyc(); set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("rst_restart_idle", outs(), 9'b000001000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
